// File: rtl/ama_riscv_dmem_arbiter.sv
// Arbitrates the single-port synchronous DMEM between the pipeline MEM stage and a host port.
// Optional starvation guard enabled by defining AMA_RISCV_DMEM_ARB_STARVE_EN.
module ama_riscv_dmem_arbiter #(
    parameter int AW         = 14,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_en,
    input  logic [3:0]    core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [31:0]   core_wdata,
    output logic          stall_core,
    input  logic          host_req_valid,
    output logic          host_req_ready,
    input  logic [3:0]    host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic          host_rsp_valid,
    output logic [31:0]   host_rsp_data,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    if ((STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_starve_max_check
        $error("STARVE_MAX must be in 1..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   rd_flag_q, rd_flag_d;
    logic   idle;
    logic   force_stall;
    logic   host_acc;

    assign idle = (state_q == IDLE);

`ifdef AMA_RISCV_DMEM_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign force_stall = idle & core_en & host_req_valid & (starve_cnt_q == STARVE_LIMIT);

    // Counts only cycles the core actually blocks a waiting host request.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (host_acc) begin
            starve_cnt_d = 8'd0;
        end else if (idle & host_req_valid & core_en & ~force_stall) begin
            if (starve_cnt_q != STARVE_LIMIT) begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_stall = 1'b0;
`endif

    assign stall_core     = force_stall;
    assign host_req_ready = idle & (~core_en | force_stall);
    assign host_acc       = host_req_valid & host_req_ready;

    always_comb begin
        state_d        = state_q;
        rd_flag_d      = rd_flag_q;
        host_rsp_valid = 1'b0;
        host_rsp_data  = 32'h0;
        mem_en         = core_en & ~stall_core;
        mem_we         = 4'h0;
        mem_addr       = core_addr;
        mem_wdata      = core_wdata;

        if (host_acc) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (mem_en) begin
            mem_we = core_we;
        end

        case (state_q)
            IDLE: begin
                if (host_acc) begin
                    state_d   = RSP;
                    rd_flag_d = (host_we == 4'h0);
                end
            end
            RSP: begin
                host_rsp_valid = 1'b1;
                host_rsp_data  = rd_flag_q ? mem_rdata : 32'h0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_flag_q <= rd_flag_d;
        end
    end

endmodule

// File: tb/tb_ama_riscv_dmem_arbiter.sv
// Directed bench for ama_riscv_dmem_arbiter with a small synchronous-read memory model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_ama_riscv_dmem_arbiter;

    localparam int AW = 14;

`ifdef AMA_RISCV_DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          core_en;
    logic [3:0]    core_we;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wdata;
    logic          stall_core;
    logic          host_req_valid;
    logic          host_req_ready;
    logic [3:0]    host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic          host_rsp_valid;
    logic [31:0]   host_rsp_data;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_cmp;
    int n_fail;

    logic [31:0] mem_model [0:255];

    ama_riscv_dmem_arbiter #(.AW(AW), .STARVE_MAX(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .core_en        (core_en),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .stall_core     (stall_core),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_data  (host_rsp_data),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-before-write synchronous memory, byte-writable.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_model[mem_addr[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem_model[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0;
        core_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (host_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %0b want 0", host_rsp_valid); end
        n_cmp++; if (host_rsp_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 0", host_rsp_data); end
        n_cmp++; if (stall_core !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall_core); end
        n_cmp++; if (host_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", host_req_ready); end
        n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rst_mem_en_hi: got %0b want 1", mem_en); end
        core_en = 1'b0;
        #1;
        n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en_lo: got %0b want 0", mem_en); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_host_read;
        @(negedge clk);
        core_en = 1'b0; host_req_valid = 1'b1; host_we = 4'h0; host_addr = 14'h010;
        #1;
        n_cmp++; if (host_req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %0b want 1", host_req_ready); end
        n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rd_mem_en: got %0b want 1", mem_en); end
        n_cmp++; if (mem_addr !== 14'h010) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 010", mem_addr); end
        n_cmp++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL rd_mem_we: got %b want 0000", mem_we); end
        @(negedge clk);
        host_req_valid = 1'b0;
        #1;
        n_cmp++; if (host_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid: got %0b want 1", host_rsp_valid); end
        n_cmp++; if (host_rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp_data: got %h want deadbeef", host_rsp_data); end
        n_cmp++; if (host_req_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_in_rsp: got %0b want 0", host_req_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (host_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_single: got %0b want 0", host_rsp_valid); end
        n_cmp++; if (host_req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_back_idle: got %0b want 1", host_req_ready); end
    endtask

    task automatic test_host_write;
        @(negedge clk);
        host_req_valid = 1'b1; host_we = 4'b0011; host_addr = 14'h020; host_wdata = 32'h1234ABCD;
        #1;
        n_cmp++; if (mem_we !== 4'b0011) begin n_fail++; $display("FAIL wr_mem_we: got %b want 0011", mem_we); end
        n_cmp++; if (mem_wdata !== 32'h1234ABCD) begin n_fail++; $display("FAIL wr_mem_wdata: got %h want 1234abcd", mem_wdata); end
        n_cmp++; if (mem_addr !== 14'h020) begin n_fail++; $display("FAIL wr_mem_addr: got %h want 020", mem_addr); end
        @(negedge clk);
        host_req_valid = 1'b0; host_we = 4'h0;
        #1;
        n_cmp++; if (host_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid: got %0b want 1", host_rsp_valid); end
        n_cmp++; if (host_rsp_data !== 32'h0) begin n_fail++; $display("FAIL wr_rsp_data: got %h want 0", host_rsp_data); end
        @(negedge clk);
        host_req_valid = 1'b1; host_addr = 14'h020;
        @(negedge clk);
        host_req_valid = 1'b0;
        #1;
        n_cmp++; if (host_rsp_data !== 32'h0000ABCD) begin n_fail++; $display("FAIL wr_readback: got %h want 0000abcd", host_rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            host_req_valid = 1'b1; host_we = 4'h0; host_addr = 14'h010;
            #1;
            n_cmp++; if (host_req_ready !== ((i % 2) == 0)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b want %0b", i, host_req_ready, (i % 2) == 0); end
            n_cmp++; if (host_rsp_valid !== ((i % 2) == 1)) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %0b want %0b", i, host_rsp_valid, (i % 2) == 1); end
        end
        @(negedge clk);
        host_req_valid = 1'b0;
    endtask

    task automatic test_contention;
        int blocked;
        blocked = STARVE_EN ? 8 : 12;
        for (int i = 0; i < blocked; i++) begin
            @(negedge clk);
            core_en = 1'b1; core_we = 4'h0; core_addr = 14'h030;
            host_req_valid = 1'b1; host_we = 4'h0; host_addr = 14'h010;
            #1;
            n_cmp++; if (stall_core !== 1'b0) begin n_fail++; $display("FAIL cont_stall[%0d]: got %0b want 0", i, stall_core); end
            n_cmp++; if (host_req_ready !== 1'b0) begin n_fail++; $display("FAIL cont_ready[%0d]: got %0b want 0", i, host_req_ready); end
            n_cmp++; if (mem_addr !== 14'h030 || mem_en !== 1'b1) begin n_fail++; $display("FAIL cont_core_mem[%0d]: got en %0b addr %h want en 1 addr 030", i, mem_en, mem_addr); end
        end
        @(negedge clk);
        if (!STARVE_EN) core_en = 1'b0;
        #1;
        n_cmp++; if (stall_core !== STARVE_EN) begin n_fail++; $display("FAIL cont_force_stall: got %0b want %0b", stall_core, STARVE_EN); end
        n_cmp++; if (host_req_ready !== 1'b1) begin n_fail++; $display("FAIL cont_accept: got %0b want 1", host_req_ready); end
        n_cmp++; if (mem_addr !== 14'h010 || mem_en !== 1'b1) begin n_fail++; $display("FAIL cont_host_mem: got en %0b addr %h want en 1 addr 010", mem_en, mem_addr); end
        @(negedge clk);
        host_req_valid = 1'b0; core_en = 1'b1;
        #1;
        n_cmp++; if (stall_core !== 1'b0) begin n_fail++; $display("FAIL cont_resume_stall: got %0b want 0", stall_core); end
        n_cmp++; if (mem_addr !== 14'h030 || mem_en !== 1'b1) begin n_fail++; $display("FAIL cont_resume_mem: got en %0b addr %h want en 1 addr 030", mem_en, mem_addr); end
        n_cmp++; if (host_rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cont_rsp_data: got %h want deadbeef", host_rsp_data); end
        @(negedge clk);
        core_en = 1'b0;
    endtask

    task automatic test_core_store_in_rsp;
        @(negedge clk);
        core_en = 1'b0; host_req_valid = 1'b1; host_we = 4'h0; host_addr = 14'h040;
        #1;
        n_cmp++; if (host_req_ready !== 1'b1) begin n_fail++; $display("FAIL st_accept: got %0b want 1", host_req_ready); end
        @(negedge clk);
        host_req_valid = 1'b0;
        core_en = 1'b1; core_we = 4'hF; core_addr = 14'h040; core_wdata = 32'h11112222;
        #1;
        n_cmp++; if (stall_core !== 1'b0) begin n_fail++; $display("FAIL st_stall: got %0b want 0", stall_core); end
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 4'hF || mem_addr !== 14'h040) begin n_fail++; $display("FAIL st_core_mem: got en %0b we %b addr %h want en 1 we 1111 addr 040", mem_en, mem_we, mem_addr); end
        n_cmp++; if (host_rsp_data !== 32'h55AA55AA) begin n_fail++; $display("FAIL st_prewrite: got %h want 55aa55aa", host_rsp_data); end
        @(negedge clk);
        core_en = 1'b0; core_we = 4'h0;
        host_req_valid = 1'b1; host_addr = 14'h040;
        @(negedge clk);
        host_req_valid = 1'b0;
        #1;
        n_cmp++; if (host_rsp_data !== 32'h11112222) begin n_fail++; $display("FAIL st_landed: got %h want 11112222", host_rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        core_en = 1'b0; host_req_valid = 1'b1; host_we = 4'h0; host_addr = 14'h010;
        @(negedge clk);
        host_req_valid = 1'b0;
        #1;
        n_cmp++; if (host_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_rsp: got %0b want 1", host_rsp_valid); end
        rst = 1'b0;
        #1;
        n_cmp++; if (host_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rsp_drop: got %0b want 0", host_rsp_valid); end
        n_cmp++; if (host_rsp_data !== 32'h0) begin n_fail++; $display("FAIL rm_rsp_data: got %h want 0", host_rsp_data); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (host_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_pulse[%0d]: got %0b want 0", i, host_rsp_valid); end
        end
        // Partly charge the starvation counter, reset, then expect the full wait again.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            core_en = 1'b1; core_addr = 14'h030; host_req_valid = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0; core_en = 1'b0; host_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            core_en = 1'b1; host_req_valid = 1'b1;
            #1;
            n_cmp++; if (stall_core !== (STARVE_EN && i == 8)) begin n_fail++; $display("FAIL rm_starve[%0d]: got %0b want %0b", i, stall_core, STARVE_EN && i == 8); end
        end
        @(negedge clk);
        core_en = 1'b0; host_req_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        mem_model[8'h10] = 32'hDEADBEEF;
        mem_model[8'h40] = 32'h55AA55AA;
        mem_rdata = 32'h0;
        rst = 1'b0;
        core_en = 1'b0; core_we = 4'h0; core_addr = '0; core_wdata = 32'h0;
        host_req_valid = 1'b0; host_we = 4'h0; host_addr = '0; host_wdata = 32'h0;

        test_reset;
        test_host_read;
        test_host_write;
        test_back_to_back;
        test_contention;
        test_core_store_in_rsp;
        test_reset_mid;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
